// File: rtl/pipeline_pkg.sv
// Shared types and sizing for the pipeline hazard controller.
package pipeline_pkg;

    localparam int REG_IDX_W = 3;
    localparam int NUM_REGS  = 8;
    localparam int MAX_PEND  = 3;
    localparam int CNT_W     = 2;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [CNT_W-1:0]     pend_cnt_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode / ID-RR / execute / writeback view of the hazard controller.
// The pipeline side is the master, the controller is the slave.
interface pipeline_hazard_ctrl_if;
    import pipeline_pkg::*;

    logic                d_valid;
    reg_idx_t            d_src1_idx;
    logic                d_src1_rd;
    reg_idx_t            d_src2_idx;
    logic                d_src2_rd;
    reg_idx_t            d_dst_idx;
    logic                d_dst_we;
    logic                d_is_halt;
    logic                rr_valid;
    reg_idx_t            rr_dst_idx;
    logic                rr_dst_we;
    logic                ex_redirect;
    logic                wb_valid;
    reg_idx_t            wb_dst_idx;
    logic                wb_we;
    logic                f_stall;
    logic                d_stall;
    logic                d_flush;
    logic                rr_flush;
    logic                issue;
    logic                halted;
    logic [NUM_REGS-1:0] sb_busy;

    modport master (
        output d_valid, d_src1_idx, d_src1_rd, d_src2_idx, d_src2_rd,
               d_dst_idx, d_dst_we, d_is_halt,
               rr_valid, rr_dst_idx, rr_dst_we,
               ex_redirect, wb_valid, wb_dst_idx, wb_we,
        input  f_stall, d_stall, d_flush, rr_flush, issue, halted, sb_busy
    );

    modport slave (
        input  d_valid, d_src1_idx, d_src1_rd, d_src2_idx, d_src2_rd,
               d_dst_idx, d_dst_we, d_is_halt,
               rr_valid, rr_dst_idx, rr_dst_we,
               ex_redirect, wb_valid, wb_dst_idx, wb_we,
        output f_stall, d_stall, d_flush, rr_flush, issue, halted, sb_busy
    );

endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register count of in-flight writes. Produces the decode hazard,
// the busy vector and a flag telling whether every count will be zero
// after this cycle's updates.
module hazard_scoreboard
    import pipeline_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                d_valid,
    input  reg_idx_t            d_src1_idx,
    input  logic                d_src1_rd,
    input  reg_idx_t            d_src2_idx,
    input  logic                d_src2_rd,
    input  reg_idx_t            d_dst_idx,
    input  logic                d_dst_we,
    input  logic                issue,
    input  logic                wb_valid,
    input  reg_idx_t            wb_dst_idx,
    input  logic                wb_we,
    input  logic                squash_valid,
    input  reg_idx_t            squash_idx,
    output logic                hazard,
    output logic [NUM_REGS-1:0] sb_busy,
    output logic                drained_next
);

    pend_cnt_t           cnt_q [NUM_REGS];
    pend_cnt_t           cnt_d [NUM_REGS];
    pend_cnt_t           eff   [NUM_REGS];
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] wb_vec;
    logic [NUM_REGS-1:0] sq_vec;
    logic [NUM_REGS-1:0] underflow;

    // Decode the per-register increment/decrement events and the effective
    // count, which already credits a same-cycle writeback (write-before-read).
    always_comb begin
        inc_vec = '0;
        wb_vec  = '0;
        sq_vec  = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            inc_vec[r] = issue & d_dst_we & (d_dst_idx == reg_idx_t'(r));
            wb_vec[r]  = wb_valid & wb_we & (wb_dst_idx == reg_idx_t'(r));
            sq_vec[r]  = squash_valid & (squash_idx == reg_idx_t'(r));
            eff[r]     = (cnt_q[r] == '0) ? '0 : (cnt_q[r] - {1'b0, wb_vec[r]});
            sb_busy[r] = (cnt_q[r] != '0);
        end
    end

    // A source with any pending write, or a destination already at the
    // outstanding-write limit, blocks the decode instruction.
    always_comb begin
        hazard = d_valid & ((d_src1_rd & (eff[d_src1_idx] != '0)) |
                            (d_src2_rd & (eff[d_src2_idx] != '0)) |
                            (d_dst_we  & (eff[d_dst_idx] == pend_cnt_t'(MAX_PEND))));
    end

    // Next counts: one possible increment, up to two decrements, clamped at zero.
    always_comb begin
        logic [CNT_W:0] sum;
        logic [CNT_W:0] dec;
        sum          = '0;
        dec          = '0;
        underflow    = '0;
        drained_next = 1'b1;
        for (int r = 0; r < NUM_REGS; r++) begin
            sum          = {1'b0, cnt_q[r]} + {{CNT_W{1'b0}}, inc_vec[r]};
            dec          = {{CNT_W{1'b0}}, wb_vec[r]} + {{CNT_W{1'b0}}, sq_vec[r]};
            underflow[r] = (sum < dec);
            cnt_d[r]     = underflow[r] ? '0 : pend_cnt_t'(sum - dec);
            if (cnt_d[r] != '0) begin
                drained_next = 1'b0;
            end
        end
    end

    // Counter registers, cleared asynchronously regardless of in-flight work.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Retiring or squashing a write that was never counted is a pipeline bug.
    no_underflow_a: assert property (@(posedge clk) disable iff (!rst) (underflow == '0));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller: priority between redirect, hazard and
// halt, plus the RUN/DRAIN/HALTED sequencer. Defining HAZARD_PERF_EN adds
// stall, flush and issue event counters as extra outputs.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_flushes,
    output logic [31:0]           perf_issued
`endif
);

    ctrl_state_t         state_q;
    ctrl_state_t         state_d;
    logic                halted_q;
    logic                halted_d;
    logic                hazard;
    logic                drained_next;
    logic                squash;
    logic [NUM_REGS-1:0] sb_busy;
    logic                f_stall;
    logic                d_stall;
    logic                d_flush;
    logic                rr_flush;
    logic                issue;

    assign squash = bus.ex_redirect & bus.rr_valid & bus.rr_dst_we;

    hazard_scoreboard u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .d_valid      (bus.d_valid),
        .d_src1_idx   (bus.d_src1_idx),
        .d_src1_rd    (bus.d_src1_rd),
        .d_src2_idx   (bus.d_src2_idx),
        .d_src2_rd    (bus.d_src2_rd),
        .d_dst_idx    (bus.d_dst_idx),
        .d_dst_we     (bus.d_dst_we),
        .issue        (issue),
        .wb_valid     (bus.wb_valid),
        .wb_dst_idx   (bus.wb_dst_idx),
        .wb_we        (bus.wb_we),
        .squash_valid (squash),
        .squash_idx   (bus.rr_dst_idx),
        .hazard       (hazard),
        .sb_busy      (sb_busy),
        .drained_next (drained_next)
    );

    // Same-cycle stall/flush/issue decisions: redirect beats hazard beats halt.
    always_comb begin
        f_stall  = 1'b0;
        d_stall  = 1'b0;
        d_flush  = 1'b0;
        rr_flush = 1'b0;
        issue    = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.ex_redirect) begin
                    d_flush  = 1'b1;
                    rr_flush = 1'b1;
                end else if (hazard || (bus.d_valid && bus.d_is_halt)) begin
                    f_stall  = 1'b1;
                    d_stall  = 1'b1;
                    rr_flush = 1'b1;
                end else begin
                    issue = bus.d_valid;
                end
            end
            DRAIN: begin
                if (bus.ex_redirect) begin
                    d_flush  = 1'b1;
                    rr_flush = 1'b1;
                end else begin
                    f_stall  = 1'b1;
                    d_stall  = 1'b1;
                    rr_flush = 1'b1;
                end
            end
            default: begin
                f_stall  = 1'b1;
                d_stall  = 1'b1;
                rr_flush = 1'b1;
            end
        endcase
    end

    // Sequencer next state; a redirect during drain means the HLT was wrong-path.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (!bus.ex_redirect && !hazard && bus.d_valid && bus.d_is_halt) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.ex_redirect) begin
                    state_d = RUN;
                end else if (drained_next) begin
                    state_d = HALTED;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
        halted_d = (state_d == HALTED);
    end

    // Sequencer state and the registered halted flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    // Combinational controls are forced low while reset is held.
    assign bus.f_stall  = f_stall  & rst;
    assign bus.d_stall  = d_stall  & rst;
    assign bus.d_flush  = d_flush  & rst;
    assign bus.rr_flush = rr_flush & rst;
    assign bus.issue    = issue    & rst;
    assign bus.halted   = halted_q;
    assign bus.sb_busy  = sb_busy;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cycles_q;
    logic [31:0] perf_stall_cycles_d;
    logic [31:0] perf_flushes_q;
    logic [31:0] perf_flushes_d;
    logic [31:0] perf_issued_q;
    logic [31:0] perf_issued_d;

    // Wrapping event counters.
    always_comb begin
        perf_stall_cycles_d = perf_stall_cycles_q + {31'd0, (state_q == RUN) & hazard};
        perf_flushes_d      = perf_flushes_q + {31'd0, bus.ex_redirect};
        perf_issued_d       = perf_issued_q + {31'd0, issue};
    end

    // Event counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cycles_q <= '0;
            perf_flushes_q      <= '0;
            perf_issued_q       <= '0;
        end else begin
            perf_stall_cycles_q <= perf_stall_cycles_d;
            perf_flushes_q      <= perf_flushes_d;
            perf_issued_q       <= perf_issued_d;
        end
    end

    assign perf_stall_cycles = perf_stall_cycles_q;
    assign perf_flushes      = perf_flushes_q;
    assign perf_issued       = perf_issued_q;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the in-order pipeline (fetch, decode, ID/RR, execute, writeback). It keeps a per-register scoreboard of in-flight writes and detects RAW/WAW hazards at decode. It generates stall and flush signals for PC_REG, IF/ID and ID/RR, squashes wrong-path work on an execute redirect, and sequences halt drain.

Parameters:
NUM_REGS, 8, architectural registers tracked (index width = 3).
MAX_PEND, 3, maximum outstanding writes per register (counter width 2).

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous reset, active-low
d_valid  in  1  decode holds a valid instruction
d_src1_idx  in  3  decode source 1 index
d_src1_rd  in  1  source 1 is read
d_src2_idx  in  3  decode source 2 index
d_src2_rd  in  1  source 2 is read
d_dst_idx  in  3  decode destination index
d_dst_we  in  1  decode instruction writes dst
d_is_halt  in  1  decode instruction is HLT
rr_valid  in  1  ID/RR holds a valid instruction
rr_dst_idx  in  3  ID/RR destination index
rr_dst_we  in  1  ID/RR instruction writes dst
ex_redirect  in  1  execute resolved a taken jump/mispredict this cycle
wb_valid  in  1  writeback retires an instruction
wb_dst_idx  in  3  writeback destination
wb_we  in  1  writeback writes register file
f_stall  out  1  hold PC_REG (we deasserted)
d_stall  out  1  hold IF/ID
d_flush  out  1  invalidate IF/ID
rr_flush  out  1  load bubble into ID/RR
issue  out  1  decode instruction advances into ID/RR this cycle
halted  out  1  core halted (registered)
sb_busy  out  8  bit r = register r has pending write

Behaviour:
- Reset (rst=0, async): all counters 0, FSM=RUN, halted=0; combinational outputs then evaluate to 0.
- Scoreboard: cnt[r] (2-bit). Effective count eff[r] = cnt[r] - (wb_valid & wb_we & wb_dst_idx==r). Regfile writes before reads, so same-cycle writeback clears the hazard.
- hazard = d_valid & ((d_src1_rd & eff[src1]!=0) | (d_src2_rd & eff[src2]!=0) | (d_dst_we & eff[dst]==MAX_PEND)).
- Next cnt[r] = cnt[r] + inc - dec, with:
  - inc = issue & d_dst_we & dst==r.
  - dec = wb match + squash match (ex_redirect & rr_valid & rr_dst_we & rr_dst_idx==r).
  - Up to 2 decrements per cycle on the same r. Underflow is a design error (assertion); the counter clamps at 0.
- Priority, per cycle in RUN:
  1. ex_redirect: d_flush=1, rr_flush=1, f_stall=0, issue=0.
  2. hazard: f_stall=1, d_stall=1, rr_flush=1, issue=0.
  3. d_valid & d_is_halt: go to DRAIN; f_stall=1, d_stall=1, rr_flush=1, issue=0.
  4. Otherwise: issue=d_valid, all stalls and flushes 0.
- FSM states:
  - RUN: as above.
  - DRAIN: f_stall=d_stall=rr_flush=1. Go to HALTED when all cnt are 0 and no inc is pending. An ex_redirect in DRAIN means the halt was wrong-path: apply the redirect outputs and return to RUN.
  - HALTED: f_stall=d_stall=rr_flush=1, halted=1 from the cycle after entry; exits only on reset.
- Latency: sb_busy reflects registered cnt, one cycle after issue/wb. Stall outputs are combinational, same cycle.
- Reset mid-operation clears the scoreboard regardless of in-flight state.

Optional Feature:
HAZARD_PERF_EN. When defined, adds three 32-bit wrapping counters, reset to 0:
- perf_stall_cycles: cycles with hazard in RUN.
- perf_flushes: ex_redirect cycles.
- perf_issued: issue cycles.
These are exposed as outputs with the same names. When undefined, the counters and their ports are absent and behaviour is otherwise identical.

Decomposition:
- pipeline_pkg holds REG_IDX_W=3, NUM_REGS, MAX_PEND, and the ctrl_state_t enum {RUN, DRAIN, HALTED}.
- One sub-module, hazard_scoreboard, owns the counters, eff/hazard computation and sb_busy. pipeline_hazard_ctrl holds the FSM, priority logic and perf counters.

Test Plan:
- RAW: issue write r3, next cycle decode reads r3 with no wb -> f_stall=d_stall=rr_flush=1, issue=0. Assert wb r3 -> same cycle hazard clears, issue=1.
- WAW limit: three writes to r5 issued, no wb -> sb_busy[5]=1, cnt=3. A fourth write to r5 stalls until one wb r5.
- Redirect squash: rr holds write r2 (cnt[2]=1), ex_redirect=1 while decode hazarded -> d_flush=rr_flush=1, f_stall=0, next cycle cnt[2]=0.
- Simultaneous events: issue write r1 plus wb r1 in the same cycle with cnt[1]=1 -> cnt[1] stays 1, no stall.
- Halt: HLT in decode with r4 pending -> DRAIN, stalls held. wb r4 -> next cycle HALTED, halted=1. A redirect in DRAIN instead returns to RUN with halted=0.
- Async reset asserted mid-DRAIN with cnt[6]=2 -> immediately sb_busy=0, halted=0, all stalls 0.
